// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_e;

  localparam int DEF_DEBOUNCE_CYCLES     = 1000000;
  localparam int DEF_REPEAT_DELAY_CYCLES = 50000000;
  localparam int DEF_REPEAT_RATE_CYCLES  = 20000000;

  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debouncer and auto-repeat FSM.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
  parameter bit REPEAT_EN           = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic inhibit,
  output logic level_nxt,
  output logic fire
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                        REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RW = cnt_w(RMAX);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          sync;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          level_q;
  logic          rise;
  rpt_state_e    state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d, rcnt_inc;

  assign sync = sync_q[1];
  assign rise = level_nxt & ~level_q;
  assign rcnt_inc = (&rcnt_q) ? rcnt_q : rcnt_q + 1'b1;

  always_comb begin
    level_nxt = level_q;
    db_cnt_d  = '0;
    if (sync != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_nxt = sync;
      end else if (&db_cnt_q) begin
        db_cnt_d = db_cnt_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // A release or the up/down interlock parks the FSM without a strobe.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    fire    = 1'b0;
    if (!level_nxt || inhibit) begin
      state_d = RPT_IDLE;
      rcnt_d  = '0;
    end else begin
      unique case (state_q)
        RPT_IDLE: begin
          if (rise) begin
            fire = 1'b1;
            rcnt_d = '0;
            if (REPEAT_EN) state_d = RPT_DELAY;
          end
        end
        RPT_DELAY: begin
          if (rcnt_q == DLY_LAST) begin
            fire    = 1'b1;
            state_d = RPT_REPEAT;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_inc;
          end
        end
        RPT_REPEAT: begin
          if (rcnt_q == RATE_LAST) begin
            fire   = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_inc;
          end
        end
        default: begin
          state_d = RPT_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      state_q  <= RPT_IDLE;
      rcnt_q   <= '0;
    end else begin
      sync_q   <= {sync_q[0], btn};
      db_cnt_q <= db_cnt_d;
      level_q  <= level_nxt;
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Three conditioned push-buttons with up/down interlock and registered strobes.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_glitch,
  output logic up_pulse,
  output logic down_pulse,
  output logic glitch_pulse,
  output logic up_held,
  output logic down_held,
  output logic glitch_held
);

  logic up_nxt, dn_nxt, gl_nxt;
  logic up_fire, dn_fire, gl_fire;
  logic ilock;

  // Uses next-cycle levels so the strobe coinciding with the second press is blocked too.
  assign ilock = up_nxt & dn_nxt;

  btn_channel #(
    .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
    .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
    .REPEAT_EN          (1'b1)
  ) u_up (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn_up),
    .inhibit  (ilock),
    .level_nxt(up_nxt),
    .fire     (up_fire)
  );

  btn_channel #(
    .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
    .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
    .REPEAT_EN          (1'b1)
  ) u_down (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn_down),
    .inhibit  (ilock),
    .level_nxt(dn_nxt),
    .fire     (dn_fire)
  );

  btn_channel #(
    .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
    .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
    .REPEAT_EN          (1'b0)
  ) u_glitch (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn_glitch),
    .inhibit  (1'b0),
    .level_nxt(gl_nxt),
    .fire     (gl_fire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_pulse     <= 1'b0;
      down_pulse   <= 1'b0;
      glitch_pulse <= 1'b0;
      up_held      <= 1'b0;
      down_held    <= 1'b0;
      glitch_held  <= 1'b0;
    end else begin
      up_pulse     <= up_fire;
      down_pulse   <= dn_fire;
      glitch_pulse <= gl_fire;
      up_held      <= up_nxt;
      down_held    <= dn_nxt;
      glitch_held  <= gl_nxt;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with short debounce/repeat timing.
module tb_btn_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic btn_glitch = 1'b0;
  logic up_pulse, down_pulse, glitch_pulse;
  logic up_held, down_held, glitch_held;

  btn_conditioner #(
    .DEBOUNCE_CYCLES    (DB),
    .REPEAT_DELAY_CYCLES(RD),
    .REPEAT_RATE_CYCLES (RR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_glitch  (btn_glitch),
    .up_pulse    (up_pulse),
    .down_pulse  (down_pulse),
    .glitch_pulse(glitch_pulse),
    .up_held     (up_held),
    .down_held   (down_held),
    .glitch_held (glitch_held)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] p;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int base = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               name, act, exp, cyc - base);
    end
  endtask

  task automatic expect_p(input int k, input logic [2:0] p);
    exp_t e;
    e.cyc = base + k;
    e.p = p;
    exp_q.push_back(e);
  endtask

  task automatic start();
    @(posedge clk);
    #1;
    base = cyc;
  endtask

  task automatic go_edge(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    btn_up = 1'b0;
    btn_down = 1'b0;
    btn_glitch = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic int outs();
    return int'({up_pulse, down_pulse, glitch_pulse,
                 up_held, down_held, glitch_held});
  endfunction

  // Pulse vector is {glitch, down, up}.
  always @(negedge clk) begin
    logic [2:0] p;
    exp_t e;
    p = {glitch_pulse, down_pulse, up_pulse};
    if (p != 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", int'(p), 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_edge", cyc - base, e.cyc - base);
        check("pulse_vec", int'(p), int'(e.p));
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      check("missing_pulse", 0, int'(e.p));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Clean up press with auto-repeat
    start();
    btn_up = 1'b1;
    expect_p(6, 3'b001);
    expect_p(16, 3'b001);
    expect_p(21, 3'b001);
    expect_p(26, 3'b001);
    go_edge(5);
    check("t1_up_held_e5", int'(up_held), 0);
    go_edge(6);
    check("t1_up_held_e6", int'(up_held), 1);
    go_edge(30);
    drain("t1_queue_empty");
    do_reset();

    // Bouncing down button never accepted
    start();
    for (int i = 0; i < 10; i++) begin
      go_edge(2 * i);
      btn_down = (i % 2 == 0);
      check("t2_down_held", int'(down_held), 0);
    end
    go_edge(20);
    btn_down = 1'b0;
    go_edge(35);
    check("t2_down_held_end", int'(down_held), 0);
    drain("t2_queue_empty");

    // Glitch button: single press strobe, no repeat
    start();
    btn_glitch = 1'b1;
    expect_p(6, 3'b100);
    go_edge(6);
    check("t3_glitch_held", int'(glitch_held), 1);
    go_edge(40);
    btn_glitch = 1'b0;
    go_edge(45);
    check("t3_glitch_held_e45", int'(glitch_held), 1);
    go_edge(46);
    check("t3_glitch_held_e46", int'(glitch_held), 0);
    go_edge(50);
    drain("t3_queue_empty");
    do_reset();

    // Up/down interlock and fresh-press requirement
    start();
    btn_up = 1'b1;
    expect_p(6, 3'b001);
    go_edge(10);
    btn_down = 1'b1;
    go_edge(16);
    check("t4_down_held", int'(down_held), 1);
    check("t4_up_held", int'(up_held), 1);
    go_edge(25);
    btn_down = 1'b0;
    go_edge(31);
    check("t4_down_released", int'(down_held), 0);
    go_edge(40);
    btn_up = 1'b0;
    go_edge(46);
    check("t4_up_released", int'(up_held), 0);
    go_edge(50);
    btn_up = 1'b1;
    expect_p(56, 3'b001);
    go_edge(58);
    drain("t4_queue_empty");
    do_reset();

    // Reset in the middle of auto-repeat with button still held
    start();
    btn_up = 1'b1;
    expect_p(6, 3'b001);
    expect_p(16, 3'b001);
    go_edge(18);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_outputs_in_reset", outs(), 0);
    go_edge(19);
    check("t5_outputs_in_reset2", outs(), 0);
    go_edge(20);
    rst_n = 1'b1;
    expect_p(26, 3'b001);
    go_edge(25);
    check("t5_up_held_e25", int'(up_held), 0);
    go_edge(30);
    check("t5_up_held_e30", int'(up_held), 1);
    drain("t5_queue_empty");
    do_reset();

    // Simultaneous up and glitch presses both strobe
    start();
    btn_up = 1'b1;
    btn_glitch = 1'b1;
    expect_p(6, 3'b101);
    go_edge(8);
    drain("t6_queue_empty");
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles needed to accept a level change (10 ms at 100 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY_CYCLES, default 50000000, cycles from press pulse to first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_RATE_CYCLES, default 20000000, cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have ports btn_up, btn_down, btn_glitch, input, 1 each, raw asynchronous push-buttons, active-high.
REQ-007 SHALL have ports up_pulse, down_pulse, glitch_pulse, output, 1 each, single-cycle command strobes to the glitch controller.
REQ-008 SHALL have ports up_held, down_held, glitch_held, output, 1 each, debounced button levels.

Function
REQ-009 SHALL pass each raw input through a two-flop synchronizer before any other logic.
REQ-010 SHALL, per channel, update the debounced level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle SHALL clear the debounce counter.
REQ-011 SHALL assert a channel's pulse for exactly one cycle, the cycle its debounced level goes 0->1, at 2+DEBOUNCE_CYCLES edges after a clean raw rise.
REQ-012 SHALL emit no pulse on a debounced 1->0 transition.
REQ-013 SHALL run a per-channel repeat FSM with states IDLE, DELAY, REPEAT: IDLE->DELAY on press pulse; DELAY->REPEAT with a pulse after REPEAT_DELAY_CYCLES held cycles; REPEAT emits a pulse every REPEAT_RATE_CYCLES held cycles.
REQ-014 SHALL return the repeat FSM to IDLE and clear its counter in the cycle the debounced level drops, from any state, with no pulse.
REQ-015 SHALL disable auto-repeat on the glitch channel (press pulse only; FSM stays IDLE).
REQ-016 SHALL, while up_held and down_held are both 1, suppress up_pulse and down_pulse and hold both repeat FSMs in IDLE; repeat SHALL resume only after a fresh press following release.
REQ-017 SHALL leave glitch_pulse unaffected by up/down activity; simultaneous up and glitch presses SHALL both pulse.
REQ-018 SHALL size all counters to clog2 of their parameter plus one bit; counters SHALL saturate, never wrap.
REQ-019 SHALL register all outputs (no combinational path from inputs).

Reset
REQ-020 SHALL, on rst_n low, clear synchronizers, debounce counters, debounced levels, repeat counters, set FSMs to IDLE, and drive all six outputs 0 immediately.
REQ-021 SHALL treat a button held across reset release as a new press: pulse after 2+DEBOUNCE_CYCLES cycles.
REQ-022 SHALL, on reset mid-repeat, emit no further pulse until the next full press sequence.

Structure
REQ-023 SHALL place the repeat FSM state enum and default cycle constants in shared package btn_pkg.
REQ-024 SHALL instantiate three copies of sub-module btn_channel (synchronizer, debouncer, repeat FSM, parameter REPEAT_EN), with interlock logic in the top level.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=5)
REQ-025 SHALL check: btn_up rises clean at edge 0 and held 30 cycles -> up_pulse at edges 6, 16, 21, 26; up_held high from edge 6.
REQ-026 SHALL check: btn_down toggles every 2 cycles for 20 cycles then settles low -> no down_pulse, down_held stays 0.
REQ-027 SHALL check: btn_glitch held 40 cycles -> exactly one glitch_pulse at edge 6.
REQ-028 SHALL check: btn_up held, btn_down pressed at edge 10 -> no up_pulse or down_pulse after down_held rises; release down -> no further up_pulse until btn_up re-pressed.
REQ-029 SHALL check: rst_n low at edge 18 during up repeat, high at edge 20 with btn_up still high -> all outputs 0 during reset, next up_pulse at edge 26.
